// File: rtl/pipe_scoreboard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_scoreboard_ctrl_pkg
// Purpose  : Shared types and constants for the pipeline scoreboard/flow
//            controller: controller state encoding and pipeline-register
//            index names (0 = IF/ID ... 3 = MEM/WB).
// Revision : 1.0 - initial release
// ============================================================================
package pipe_scoreboard_ctrl_pkg;

  // RUN   : normal issue, stalls and redirects
  // DRAIN : front end frozen while outstanding long ops retire
  // TRAP  : one-cycle trap acknowledge, whole pipe flushed
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2
  } sb_state_t;

  // Pipeline register indices into stage_en / stage_clr
  localparam int IF_ID   = 0;
  localparam int ID_EXE  = 1;
  localparam int EXE_MEM = 2;
  localparam int MEM_WB  = 3;

endpackage : pipe_scoreboard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_scoreboard_ctrl_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : sb_counter_bank
// Purpose  : NREGS pending-writeback counters (x0 untracked) with one
//            increment and one decrement port per cycle, per-register
//            nonzero / saturation flags and a sticky underflow flag.
// Ports    : clk_i, reset_i        - clock, async active-high reset
//            inc_i, inc_idx_i      - add one pending op for register inc_idx_i
//            dec_i, dec_idx_i      - retire one pending op for dec_idx_i
//            nonzero_o[NREGS]      - counter r is nonzero
//            full_o[NREGS]         - counter r is at 2^CNT_W-1
//            busy_o                - any counter nonzero
//            underflow_o           - sticky: decrement hit a zero counter
// Revision : 1.0 - initial release
// ============================================================================
module sb_counter_bank #(
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     inc_i,
  input  logic [$clog2(NREGS)-1:0] inc_idx_i,
  input  logic                     dec_i,
  input  logic [$clog2(NREGS)-1:0] dec_idx_i,
  output logic [NREGS-1:0]         nonzero_o,
  output logic [NREGS-1:0]         full_o,
  output logic                     busy_o,
  output logic                     underflow_o
);

  localparam int IDX_W = $clog2(NREGS);

  logic underflow_q;
  logic underflow_d;
  logic w_dec_valid;
  logic w_same_reg;

  // Completions reported for x0 carry no state and are dropped.
  assign w_dec_valid = dec_i && (dec_idx_i != '0);
  assign w_same_reg  = inc_i && (inc_idx_i == dec_idx_i);

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign nonzero_o[r] = 1'b0;
      assign full_o[r]    = 1'b0;
    end else begin : g_cnt
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             w_inc_hit;
      logic             w_dec_hit;

      assign w_inc_hit = inc_i && (inc_idx_i == IDX_W'(r));
      assign w_dec_hit = w_dec_valid && (dec_idx_i == IDX_W'(r));

      // A simultaneous issue and completion on the same register cancel.
      // The saturation guard is belt-and-braces: the issue logic already
      // refuses to fire a long op into a full counter.
      always_comb begin
        cnt_d = cnt_q;
        if (w_inc_hit && !w_dec_hit) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else if (w_dec_hit && !w_inc_hit) begin
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
      end

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
      end

      assign nonzero_o[r] = (cnt_q != '0);
      assign full_o[r]    = (cnt_q == '1);
    end
  end

  assign busy_o = |nonzero_o;

  // Underflow: a retire for a register with nothing pending, unless an
  // issue to that same register lands in the same cycle and absorbs it.
  always_comb begin
    underflow_d = underflow_q;
    if (w_dec_valid && !nonzero_o[dec_idx_i] && !w_same_reg) underflow_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) underflow_q <= 1'b0;
    else         underflow_q <= underflow_d;
  end

  assign underflow_o = underflow_q;

endmodule : sb_counter_bank
`default_nettype wire

// File: rtl/pipe_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_scoreboard_ctrl
// Purpose  : Long-latency writeback scoreboard plus trap-drain controller.
//            Stalls ID on pending long results (RAW, WAW, counter full),
//            orders redirects over stalls, and drains outstanding long ops
//            before acknowledging a trap. Drives enable/clear for an
//            NUM_STAGES-deep chain of pipeline registers.
// Ports    : clk_i, reset_i                   - clock, async active-high reset
//            issue_*_i                        - instruction presented in ID
//            complete_valid_i/complete_rd_i   - long unit retired/cancelled
//            ext_stall_i                      - external ID stall (load-use)
//            redirect_valid_i/redirect_stage_i- redirect from that register
//            trap_req_i                       - level trap request
//            pc_en_o, stage_en_o, stage_clr_o - pipeline control
//            issue_fire_o                     - ID instruction accepted
//            trap_ack_o                       - one-cycle trap acknowledge
//            sb_busy_o                        - any long op outstanding
//            err_underflow_o                  - sticky retire-underflow flag
// Revision : 1.0 - initial release
// ============================================================================
module pipe_scoreboard_ctrl
  import pipe_scoreboard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int NREGS      = 32,
  parameter int CNT_W      = 2
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          issue_valid_i,
  input  logic [$clog2(NREGS)-1:0]      issue_rs1_i,
  input  logic [$clog2(NREGS)-1:0]      issue_rs2_i,
  input  logic                          issue_rs1_use_i,
  input  logic                          issue_rs2_use_i,
  input  logic [$clog2(NREGS)-1:0]      issue_rd_i,
  input  logic                          issue_rd_we_i,
  input  logic                          issue_long_i,
  input  logic                          complete_valid_i,
  input  logic [$clog2(NREGS)-1:0]      complete_rd_i,
  input  logic                          ext_stall_i,
  input  logic                          redirect_valid_i,
  input  logic [$clog2(NUM_STAGES)-1:0] redirect_stage_i,
  input  logic                          trap_req_i,
  output logic                          pc_en_o,
  output logic [NUM_STAGES-1:0]         stage_en_o,
  output logic [NUM_STAGES-1:0]         stage_clr_o,
  output logic                          issue_fire_o,
  output logic                          trap_ack_o,
  output logic                          sb_busy_o,
  output logic                          err_underflow_o
);

  sb_state_t         state_q;
  sb_state_t         state_d;

  logic [NREGS-1:0]  w_nonzero;
  logic [NREGS-1:0]  w_full;
  logic              w_busy;
  logic              w_rd_nz;
  logic              w_raw;
  logic              w_waw;
  logic              w_sat;
  logic              w_hazard;
  logic              w_stall;
  logic              w_inc;

  // --------------------------------------------------------------------------
  // Hazard detection. x0 never hazards: its nonzero/full flags are tied low.
  // --------------------------------------------------------------------------
  assign w_rd_nz  = (issue_rd_i != '0);
  assign w_raw    = (issue_rs1_use_i && w_nonzero[issue_rs1_i]) ||
                    (issue_rs2_use_i && w_nonzero[issue_rs2_i]);
  // A short op must not overtake a pending long write to the same rd.
  assign w_waw    = issue_rd_we_i && !issue_long_i && w_nonzero[issue_rd_i];
  // Another long op to an rd whose counter is full cannot be tracked.
  assign w_sat    = issue_long_i && issue_rd_we_i && w_full[issue_rd_i];
  assign w_hazard = w_raw || w_waw || w_sat;
  assign w_stall  = issue_valid_i && (w_hazard || ext_stall_i);

  // Only accepted long ops that really write a tracked register count.
  assign w_inc    = issue_fire_o && issue_long_i && issue_rd_we_i && w_rd_nz;

  sb_counter_bank #(
    .NREGS (NREGS),
    .CNT_W (CNT_W)
  ) u_bank (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .inc_i       (w_inc),
    .inc_idx_i   (issue_rd_i),
    .dec_i       (complete_valid_i),
    .dec_idx_i   (complete_rd_i),
    .nonzero_o   (w_nonzero),
    .full_o      (w_full),
    .busy_o      (w_busy),
    .underflow_o (err_underflow_o)
  );

  assign sb_busy_o = w_busy;

  // --------------------------------------------------------------------------
  // Controller state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // Next state and pipeline control. While reset is high every output sits
  // at its idle value regardless of inputs.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pc_en_o      = 1'b1;
    stage_en_o   = '1;
    stage_clr_o  = '0;
    issue_fire_o = 1'b0;
    trap_ack_o   = 1'b0;

    if (!reset_i) begin
      unique case (state_q)
        ST_RUN: begin
          issue_fire_o = issue_valid_i && !w_hazard && !ext_stall_i && !redirect_valid_i;
          if (redirect_valid_i) begin
            // Squash every register younger than or equal to the redirecting
            // one; the fetch side restarts, so PC keeps moving.
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (i <= int'(redirect_stage_i)) stage_clr_o[i] = 1'b1;
            end
          end else if (w_stall) begin
            pc_en_o            = 1'b0;
            stage_en_o[IF_ID]  = 1'b0;
            stage_clr_o[ID_EXE] = 1'b1;
          end
          if (trap_req_i) state_d = ST_DRAIN;
        end

        ST_DRAIN: begin
          // Front end frozen with a bubble into EXE; older stages keep
          // retiring. Redirects and issue are ignored here.
          pc_en_o             = 1'b0;
          stage_en_o[IF_ID]   = 1'b0;
          stage_clr_o[ID_EXE] = 1'b1;
          // A completion this cycle still has to land before the trap.
          if (!w_busy && !complete_valid_i) state_d = ST_TRAP;
        end

        ST_TRAP: begin
          trap_ack_o  = 1'b1;
          stage_clr_o = '1;
          state_d     = ST_RUN;
        end

        default: state_d = ST_RUN;
      endcase
    end
  end

endmodule : pipe_scoreboard_ctrl
`default_nettype wire

// File: tb/tb_pipe_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_scoreboard_ctrl
// Purpose  : Self-checking bench. A behavioural model (pending-count array
//            plus a mode variable) predicts every output each cycle; directed
//            sequences add literal expectations, then randomized traffic runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_scoreboard_ctrl;

  localparam int NS  = 4;
  localparam int NR  = 32;
  localparam int CW  = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, rs1_use, rs2_use, rd_we, is_long;
  logic [4:0] rs1, rs2, rd, comp_rd;
  logic       comp_valid, ext_stall, redir_valid, trap_req;
  logic [1:0] redir_stage;
  logic       pc_en, issue_fire, trap_ack, sb_busy, err_uf;
  logic [3:0] stage_en, stage_clr;

  always #5 clk = ~clk;

  pipe_scoreboard_ctrl #(.NUM_STAGES(NS), .NREGS(NR), .CNT_W(CW)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .issue_valid_i    (issue_valid),
    .issue_rs1_i      (rs1),
    .issue_rs2_i      (rs2),
    .issue_rs1_use_i  (rs1_use),
    .issue_rs2_use_i  (rs2_use),
    .issue_rd_i       (rd),
    .issue_rd_we_i    (rd_we),
    .issue_long_i     (is_long),
    .complete_valid_i (comp_valid),
    .complete_rd_i    (comp_rd),
    .ext_stall_i      (ext_stall),
    .redirect_valid_i (redir_valid),
    .redirect_stage_i (redir_stage),
    .trap_req_i       (trap_req),
    .pc_en_o          (pc_en),
    .stage_en_o       (stage_en),
    .stage_clr_o      (stage_clr),
    .issue_fire_o     (issue_fire),
    .trap_ack_o       (trap_ack),
    .sb_busy_o        (sb_busy),
    .err_underflow_o  (err_uf)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: pending long ops per register, and controller mode
  // (0 = running, 1 = draining, 2 = acknowledging trap).
  int mcnt [NR];
  int mmode;
  bit merr;
  bit e_pc, e_fire, e_ack, e_busy, e_err;
  logic [3:0] e_en, e_clr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit pending(input logic [4:0] r);
    return (r != 0) && (mcnt[r] > 0);
  endfunction

  function automatic void model_eval();
    bit hz;
    if (reset) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      mmode = 0;
      merr  = 1'b0;
    end
    hz = (rs1_use && pending(rs1)) || (rs2_use && pending(rs2)) ||
         (rd_we && !is_long && pending(rd)) ||
         (rd_we && is_long && rd != 0 && mcnt[rd] == MAXC);
    e_busy = 1'b0;
    foreach (mcnt[i]) if (mcnt[i] > 0) e_busy = 1'b1;
    e_err = merr;
    e_pc = 1'b1; e_en = 4'hF; e_clr = 4'h0; e_fire = 1'b0; e_ack = 1'b0;
    if (!reset) begin
      if (mmode == 0) begin
        e_fire = issue_valid && !hz && !ext_stall && !redir_valid;
        if (redir_valid) e_clr = 4'((1 << (int'(redir_stage) + 1)) - 1);
        else if (issue_valid && (hz || ext_stall)) begin
          e_pc = 1'b0; e_en = 4'b1110; e_clr = 4'b0010;
        end
      end else if (mmode == 1) begin
        e_pc = 1'b0; e_en = 4'b1110; e_clr = 4'b0010;
      end else begin
        e_ack = 1'b1; e_clr = 4'hF;
      end
    end
  endfunction

  function automatic void model_update();
    bit inc, dec;
    if (reset) return;
    inc = e_fire && is_long && rd_we && rd != 0;
    dec = comp_valid && comp_rd != 0;
    if (!(inc && dec && rd == comp_rd)) begin
      if (inc && mcnt[rd] < MAXC) mcnt[rd]++;
      if (dec) begin
        if (mcnt[comp_rd] == 0) merr = 1'b1;
        else mcnt[comp_rd]--;
      end
    end
    case (mmode)
      0: if (trap_req) mmode = 1;
      1: if (!e_busy && !comp_valid) mmode = 2;
      default: mmode = 0;
    endcase
  endfunction

  // Compare point: opposite edge, inputs have been stable since posedge+1.
  task automatic sample();
    @(negedge clk);
    model_eval();
    check("pc_en",      32'(pc_en),      32'(e_pc));
    check("stage_en",   32'(stage_en),   32'(e_en));
    check("stage_clr",  32'(stage_clr),  32'(e_clr));
    check("issue_fire", 32'(issue_fire), 32'(e_fire));
    check("trap_ack",   32'(trap_ack),   32'(e_ack));
    check("sb_busy",    32'(sb_busy),    32'(e_busy));
    check("err_uf",     32'(err_uf),     32'(e_err));
    model_update();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; rs1 = 0; rs2 = 0; rs1_use = 0; rs2_use = 0;
    rd = 0; rd_we = 0; is_long = 0; comp_valid = 0; comp_rd = 0;
    ext_stall = 0; redir_valid = 0; redir_stage = 0; trap_req = 0;
  endtask

  task automatic issue(input logic [4:0] d, input bit lng, input logic [4:0] s1, input bit u1);
    issue_valid = 1; rd = d; rd_we = 1; is_long = lng; rs1 = s1; rs1_use = u1;
    rs2 = 0; rs2_use = 0;
  endtask

  task automatic complete(input bit v, input logic [4:0] r);
    comp_valid = v; comp_rd = r;
  endtask

  initial begin
    bit trap_pend;
    int trap_age;
    idle_inputs();
    reset = 1;
    #1;
    sample();
    check("rst_pc_en", 32'(pc_en), 32'd1);
    check("rst_clr",   32'(stage_clr), 32'd0);
    check("rst_busy",  32'(sb_busy), 32'd0);
    adv();
    reset = 0;

    // ---- long op to x5, dependent add stalls until completion -----------
    issue(5, 1, 0, 0);
    sample(); check("x5_issue_fire", 32'(issue_fire), 32'd1); adv();
    issue(6, 0, 5, 1);
    sample(); check("x5_dep_stall", 32'(issue_fire), 32'd0);
    check("x5_bubble", 32'(stage_clr), 32'b0010); adv();
    sample(); check("x5_bubble2", 32'(stage_clr), 32'b0010); adv();
    complete(1, 5);
    sample(); check("x5_cmpl_cycle", 32'(issue_fire), 32'd0); adv();
    complete(0, 0);
    sample(); check("x5_fire_next", 32'(issue_fire), 32'd1); adv();

    // ---- saturation on x7 ------------------------------------------------
    for (int k = 0; k < 3; k++) begin
      issue(7, 1, 0, 0);
      sample(); check("x7_fill", 32'(issue_fire), 32'd1); adv();
    end
    sample(); check("x7_sat_stall", 32'(issue_fire), 32'd0); adv();
    issue_valid = 0; complete(1, 7);
    sample(); adv();
    issue(7, 1, 0, 0); complete(1, 7);
    sample(); check("x7_inc_dec", 32'(issue_fire), 32'd1); adv();
    complete(0, 0);
    sample(); check("x7_to_max", 32'(issue_fire), 32'd1); adv();
    sample(); check("x7_sat_again", 32'(issue_fire), 32'd0); adv();
    issue_valid = 0;
    for (int k = 0; k < 3; k++) begin complete(1, 7); sample(); adv(); end
    complete(0, 0);
    sample(); check("x7_empty", 32'(sb_busy), 32'd0); adv();

    // ---- stall plus redirect from EXE/MEM --------------------------------
    issue(8, 0, 0, 0); ext_stall = 1; redir_valid = 1; redir_stage = 2;
    sample();
    check("redir_pc", 32'(pc_en), 32'd1);
    check("redir_clr", 32'(stage_clr), 32'b0111);
    check("redir_fire", 32'(issue_fire), 32'd0);
    adv();
    idle_inputs();

    // ---- trap with two long ops outstanding ------------------------------
    issue(3, 1, 0, 0); sample(); adv();
    issue(4, 1, 0, 0); sample(); adv();
    idle_inputs(); trap_req = 1;
    sample(); adv();
    redir_valid = 1; redir_stage = 3;
    sample(); check("drain_pc", 32'(pc_en), 32'd0);
    check("drain_redir_ign", 32'(stage_clr), 32'b0010); adv();
    redir_valid = 0; complete(1, 3);
    sample(); check("drain_hold1", 32'(pc_en), 32'd0); adv();
    complete(1, 4);
    sample(); check("drain_hold2", 32'(trap_ack), 32'd0); adv();
    complete(0, 0);
    sample(); check("drain_last", 32'(pc_en), 32'd0); adv();
    sample();
    check("trap_ack", 32'(trap_ack), 32'd1);
    check("trap_clr", 32'(stage_clr), 32'hF);
    check("trap_pc", 32'(pc_en), 32'd1);
    trap_req = 0; adv();

    // ---- underflow on x9 -------------------------------------------------
    complete(1, 9); sample(); adv();
    complete(0, 0);
    sample(); check("uf_set", 32'(err_uf), 32'd1); adv();
    sample(); check("uf_sticky", 32'(err_uf), 32'd1);
    check("uf_busy", 32'(sb_busy), 32'd0); adv();

    // ---- reset during DRAIN ----------------------------------------------
    issue(10, 1, 0, 0); sample(); adv();
    idle_inputs(); trap_req = 1;
    sample(); adv();
    sample(); check("rd_drain_busy", 32'(sb_busy), 32'd1); adv();
    reset = 1;
    sample();
    check("rd_busy", 32'(sb_busy), 32'd0);
    check("rd_pc", 32'(pc_en), 32'd1);
    adv();
    reset = 0; trap_req = 0;
    for (int k = 0; k < 3; k++) begin
      sample(); check("rd_no_ack", 32'(trap_ack), 32'd0); adv();
    end

    // ---- randomized traffic ----------------------------------------------
    trap_pend = 0; trap_age = 0;
    for (int c = 0; c < 3000; c++) begin
      int np;
      logic [4:0] pick [$];
      issue_valid = ($urandom_range(0, 9) < 7);
      rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
      rs1_use = 1'($urandom); rs2_use = 1'($urandom);
      rd = 5'($urandom_range(0, 7)); rd_we = ($urandom_range(0, 9) < 8);
      is_long = ($urandom_range(0, 9) < 4);
      ext_stall = ($urandom_range(0, 9) == 0);
      redir_valid = ($urandom_range(0, 9) == 0);
      redir_stage = 2'($urandom);
      pick.delete();
      for (int r = 1; r < 8; r++) if (mcnt[r] > 0) pick.push_back(5'(r));
      np = pick.size();
      if (np > 0 && $urandom_range(0, 9) < 4) complete(1, pick[$urandom_range(0, np - 1)]);
      else complete(0, 0);
      if (!trap_pend && $urandom_range(0, 59) == 0) begin trap_pend = 1; trap_age = 0; end
      trap_req = trap_pend;
      sample();
      if (trap_pend) begin
        trap_age++;
        if (e_ack) trap_pend = 0;
        else if (trap_age > 400) begin
          check("trap_timeout", 32'(trap_age), 32'd0);
          trap_pend = 0;
        end
      end
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipe_scoreboard_ctrl
`default_nettype wire
